load_unit: RTL

Sequential load path of the memory stage: accepts a load request (opcode, byte address, destination tag) and issues a word-aligned read to data memory over a req/gnt/rvalid handshake. It then selects the addressed byte or halfword lane, sign- or zero-extends it, and presents the result to write-back under a valid/ready handshake. It is the read-side counterpart of the store-data merge path and shares its opcode set and lane rules.

---
 rtl/load_unit_pkg.sv | 36 +++
 rtl/load_unit_extract.sv | 28 ++
 rtl/load_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Shared widths, memory opcodes and FSM states for the load path.
// The opcode codes are common to the load and store-data paths.
package load_unit_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int MEM_OP_WIDTH  = 4;
  localparam int REG_IDX_WIDTH = 5;

  localparam logic [MEM_OP_WIDTH-1:0] MEM_LB  = 4'b0000;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LH  = 4'b0001;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LW  = 4'b0010;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU = 4'b0100;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU = 4'b0101;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SB  = 4'b1000;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SH  = 4'b1001;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic is_load(input logic [MEM_OP_WIDTH-1:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                         input logic [1:0] lane);
    return (((op == MEM_LH) || (op == MEM_LHU)) && lane[0]) ||
           ((op == MEM_LW) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Lane select and sign/zero extension of a loaded word; purely combinational.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] op,
  input  logic [1:0]              lane,
  input  logic [CPU_WIDTH-1:0]    rdata,
  output logic [CPU_WIDTH-1:0]    data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = rdata[{lane[1], 4'b0000} +: 16];
    data     = '0;
    case (op)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'b0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'b0, half_sel};
      MEM_LW:  data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Memory-stage load path: word-aligned read over req/gnt/rvalid, lane extract,
// and a held result under a valid/ready handshake to write-back.
module load_unit
  import load_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [MEM_OP_WIDTH-1:0]  mem_op,
  input  logic [CPU_WIDTH-1:0]     mem_addr,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx,
  output logic                     dmem_req,
  output logic [CPU_WIDTH-1:0]     dmem_addr,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [CPU_WIDTH-1:0]     dmem_rdata,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [CPU_WIDTH-1:0]     wb_rdata,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx,
  output logic                     misalign
);

  state_t                   state, next_state;
  logic                     accept;
  logic                     bad_align;
  logic [MEM_OP_WIDTH-1:0]  op_q;
  logic [1:0]               lane_q;
  logic [CPU_WIDTH-3:0]     word_q;
  logic [REG_IDX_WIDTH-1:0] rd_q;
  logic [CPU_WIDTH-1:0]     rdata_q;
  logic                     misalign_q;
  logic [CPU_WIDTH-1:0]     extracted;

  assign bad_align = is_misaligned(mem_op, mem_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    dmem_req   = 1'b0;
    wb_valid   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid && is_load(mem_op)) begin
          accept = 1'b1;
          if (!bad_align) next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rvalid) next_state = ST_RESP;
      end
      ST_RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Misaligned loads never reach memory; they only leave a one-cycle flag behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && bad_align;
      if (accept && !bad_align) begin
        op_q   <= mem_op;
        lane_q <= mem_addr[1:0];
        word_q <= mem_addr[CPU_WIDTH-1:2];
        rd_q   <= rd_idx;
      end
      if (state == ST_WAIT && dmem_rvalid) rdata_q <= extracted;
    end
  end

  load_extract u_extract (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (dmem_rdata),
    .data  (extracted)
  );

  assign dmem_addr = dmem_req ? {word_q, 2'b00} : '0;
  assign wb_rdata  = rdata_q;
  assign wb_rd_idx = rd_q;
  assign misalign  = misalign_q;

endmodule
